// File: rtl/iccm_loader.sv
// Streams a length-prefixed little-endian image into instruction memory while holding the core in reset.
// Optional read-back verify of every written word is compiled in with ICCM_LOADER_VERIFY_EN.
module iccm_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              req_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [3:0]        wmask_o,
  input  logic [31:0]       rdata_i,
  input  logic              rvalid_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              core_rst_o
);

  localparam int unsigned CNT_W = 16;
`ifdef ICCM_LOADER_VERIFY_EN
  localparam int unsigned RD_TIMEOUT = 8;
  localparam int unsigned TMO_W      = 3;
`endif

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    HDR0  = 4'd1,
    HDR1  = 4'd2,
    DATA  = 4'd3,
    WRITE = 4'd4,
`ifdef ICCM_LOADER_VERIFY_EN
    RD    = 4'd5,
    RWAIT = 4'd6,
`endif
    DONE  = 4'd7,
    ERR   = 4'd8
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [31:0]        word_q, word_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               core_rst_q, core_rst_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [3:0]         wmask_q, wmask_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               word_done;
  logic [CNT_W-1:0]   hdr_n_c;
  logic               last_word_c;
`ifdef ICCM_LOADER_VERIFY_EN
  logic [TMO_W-1:0]   tmo_q, tmo_d;
`else
  logic               unused_c;
  assign unused_c = ^{rdata_i, rvalid_i};
`endif

  assign hdr_n_c     = {byte_i, n_q[7:0]};
  assign last_word_c = (idx_q == n_q - CNT_W'(1));

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      n_q        <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wmask_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef ICCM_LOADER_VERIFY_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
      rdy_q      <= rdy_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef ICCM_LOADER_VERIFY_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Next state; outputs are decoded from the next state so they align with it
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    idx_d      = idx_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    word_done  = 1'b0;
`ifdef ICCM_LOADER_VERIFY_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d    = HDR0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          core_rst_d = 1'b1;
          idx_d      = '0;
          byte_cnt_d = '0;
        end
      end
      HDR0: begin
        if (byte_valid_i) begin
          n_d     = {8'h00, byte_i};
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (byte_valid_i) begin
          n_d = hdr_n_c;
          if (hdr_n_c != '0 && 32'(hdr_n_c) <= MAX_WORDS) begin
            state_d = DATA;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      DATA: begin
        // Bytes enter at the top so the first byte ends up in [7:0]
        if (byte_valid_i) begin
          word_d     = {byte_i, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
`ifdef ICCM_LOADER_VERIFY_EN
        state_d = RD;
`else
        word_done = 1'b1;
`endif
      end
`ifdef ICCM_LOADER_VERIFY_EN
      RD: begin
        tmo_d   = '0;
        state_d = RWAIT;
      end
      RWAIT: begin
        if (rvalid_i) begin
          if (rdata_i != word_q) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            word_done = 1'b1;
          end
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 2)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (last_word_c) begin
        state_d    = DONE;
        done_d     = 1'b1;
        core_rst_d = 1'b0;
      end else begin
        idx_d   = idx_q + CNT_W'(1);
        state_d = DATA;
      end
    end

    rdy_d   = (state_d == HDR0) || (state_d == HDR1) || (state_d == DATA);
    busy_d  = !((state_d == IDLE) || (state_d == DONE) || (state_d == ERR));
    we_d    = (state_d == WRITE);
    req_d   = we_d;
`ifdef ICCM_LOADER_VERIFY_EN
    req_d   = we_d || (state_d == RD);
`endif
    wmask_d = we_d ? 4'hF : 4'h0;
    addr_d  = req_d ? ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d) : '0;
    wdata_d = we_d ? word_d : '0;
  end

  assign byte_ready_o = rdy_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign core_rst_o   = core_rst_q;
  assign req_o        = req_q;
  assign we_o         = we_q;
  assign wmask_o      = wmask_q;
  assign addr_o       = addr_q;
  assign wdata_o      = wdata_q;

endmodule

// File: tb/tb_iccm_loader.sv
// Scoreboard bench for iccm_loader: random images, header bounds, reset and start-while-busy cases.
module tb_iccm_loader;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned MAX_WORDS = 1024;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              byte_valid_i;
  logic [7:0]        byte_i;
  logic              byte_ready_o;
  logic              req_o;
  logic              we_o;
  logic [ADDR_W-1:0] addr_o;
  logic [31:0]       wdata_o;
  logic [3:0]        wmask_o;
  logic [31:0]       rdata_i = '0;
  logic              rvalid_i = 1'b0;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              core_rst_o;

  iccm_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .BASE_ADDR(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .wmask_o(wmask_o),
    .rdata_i(rdata_i), .rvalid_i(rvalid_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .core_rst_o(core_rst_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rd_cyc = 0;
  int          err_cyc = 0;
  bit          err_prev = 1'b0;
  bit          wr_prev = 1'b0;
  logic [ADDR_W-1:0] last_wr = '0;
  wr_t         exp_q[$];
  logic [31:0] img[$];
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  bit          hold_rvalid = 1'b0;
  int          corrupt_idx = -1;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory: answers a read one cycle later, optionally flipping bit 0 of one address
  always @(posedge clk_i) begin
    rvalid_i <= 1'b0;
    if (req_o && we_o) mem[addr_o] <= wdata_o;
    if (req_o && !we_o && !hold_rvalid) begin
      rvalid_i <= 1'b1;
      rdata_i  <= mem[addr_o] ^ ((int'(addr_o) == corrupt_idx) ? 32'h1 : 32'h0);
    end
  end

  // Monitor: pops the scoreboard on every write strobe
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (req_o && we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=0x%0h@0x%0h required=none", wdata_o, addr_o);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(addr_o), 32'(e.addr));
          chk("wr_data", wdata_o, e.data);
          chk("wr_mask", 32'(wmask_o), 32'hF);
        end
        last_wr = addr_o;
      end
`ifdef ICCM_LOADER_VERIFY_EN
      if (req_o && !we_o) begin
        chk("rd_addr", 32'(addr_o), 32'(last_wr));
        chk("rd_mask", 32'(wmask_o), 32'h0);
        rd_cyc = cyc;
      end
`else
      if (req_o && !we_o) chk("no_read_strobe", 32'(req_o && !we_o), 32'h0);
      if (wr_prev && busy_o) chk("rdy_after_write", 32'(byte_ready_o), 32'h1);
`endif
      if (err_o && !err_prev) err_cyc = cyc;
      err_prev = err_o;
      wr_prev  = req_o && we_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int budget;
    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    byte_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
    byte_valid_i = 1'b1;
    byte_i       = b;
    budget       = 0;
    while (!byte_ready_o && budget < 100) begin
      @(negedge clk_i);
      budget++;
    end
    if (!byte_ready_o) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=stalled required=accepted byte=0x%0h", b);
    end
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic fill(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom());
  endtask

  // Expected writes come straight from the image: word i lands at address i
  task automatic load(input logic [15:0] n, input int n_writes, input bit exp_done,
                      input bit mid_start, input bit end_start);
    logic [31:0] wv;
    for (int i = 0; i < n_writes; i++) exp_q.push_back('{addr: ADDR_W'(i), data: img[i]});
    pulse_start();
    chk("start_busy", 32'(busy_o), 32'h1);
    chk("start_done_clr", 32'(done_o), 32'h0);
    chk("start_err_clr", 32'(err_o), 32'h0);
    chk("start_core_rst", 32'(core_rst_o), 32'h1);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int w = 0; w < img.size(); w++) begin
      wv = img[w];
      for (int b = 0; b < 4; b++) begin
        send_byte(wv[8*b +: 8]);
        if (mid_start && w == 0 && b == 1) pulse_start();
      end
    end
    if (end_start) pulse_start();
    for (int k = 0; k < 40 && busy_o; k++) @(negedge clk_i);
    chk("end_busy", 32'(busy_o), 32'h0);
    chk("end_done", 32'(done_o), 32'(exp_done));
    chk("end_err", 32'(err_o), 32'(!exp_done));
    chk("end_core_rst", 32'(core_rst_o), 32'(!exp_done));
    chk("end_req", 32'(req_o), 32'h0);
    chk("writes_left", 32'(exp_q.size()), 32'h0);
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy_o), 32'h0);
    chk({tag, "_done"}, 32'(done_o), 32'h0);
    chk({tag, "_err"}, 32'(err_o), 32'h0);
    chk({tag, "_core_rst"}, 32'(core_rst_o), 32'h1);
    chk({tag, "_ready"}, 32'(byte_ready_o), 32'h0);
    chk({tag, "_req"}, 32'({req_o, we_o}), 32'h0);
    chk({tag, "_mask"}, 32'(wmask_o), 32'h0);
    chk({tag, "_addr"}, 32'(addr_o), 32'h0);
    chk({tag, "_wdata"}, wdata_o, 32'h0);
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    byte_valid_i = 1'b0;
    byte_i       = '0;
    repeat (3) @(negedge clk_i);
    check_reset("por");
    rst_i = 1'b0;
    @(negedge clk_i);

    img.delete();
    img.push_back(32'h12345678);
    img.push_back(32'hDEADBEEF);
    load(16'd2, 2, 1'b1, 1'b0, 1'b0);

    img.delete();
    load(16'd0, 0, 1'b0, 1'b0, 1'b0);
    load(16'd1025, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(1, 8));
      fill(n);
      load(16'(n), n, 1'b1, t == 1, t == 3);
    end

    // Abort after three of four data bytes, then reload a single word
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    for (int b = 0; b < 3; b++) send_byte(8'(8'h11 * (b + 1)));
    rst_i = 1'b1;
    @(negedge clk_i);
    check_reset("midload");
    rst_i = 1'b0;
    @(negedge clk_i);
    fill(1);
    load(16'd1, 1, 1'b1, 1'b0, 1'b0);

    fill(int'(MAX_WORDS));
    load(16'(MAX_WORDS), int'(MAX_WORDS), 1'b1, 1'b0, 1'b0);

`ifdef ICCM_LOADER_VERIFY_EN
    fill(2);
    corrupt_idx = 1;
    load(16'd3, 2, 1'b0, 1'b0, 1'b0);
    corrupt_idx = -1;

    hold_rvalid = 1'b1;
    fill(1);
    load(16'd1, 1, 1'b0, 1'b0, 1'b0);
    chk("rd_timeout_cycles", 32'(err_cyc - rd_cyc), 32'd8);
    hold_rvalid = 1'b0;
`endif

    fill(3);
    load(16'd3, 3, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iccm_loader.md
ICCM_LOADER -- requirements
Module: iccm_loader

Interface
REQ-001 Parameter ADDR_W, default 12: width of the memory word address.
REQ-002 Parameter MAX_WORDS, default 1024: largest accepted image length in words.
REQ-003 Parameter BASE_ADDR, default 0: word address of the first image word. BASE_ADDR+MAX_WORDS-1 SHALL fit in ADDR_W bits.
REQ-004 clk_i  in  1: single clock; every flop SHALL be clocked on its rising edge.
REQ-005 rst_i  in  1: synchronous, active-high reset.
REQ-006 start_i  in  1: one-cycle pulse that begins a load; SHALL be ignored while busy_o=1.
REQ-007 byte_valid_i  in  1: a byte is present on byte_i.
REQ-008 byte_i  in  8: image stream byte.
REQ-009 byte_ready_o  out  1: a byte is accepted in any cycle where byte_valid_i and byte_ready_o are both 1.
REQ-010 req_o  out  1: memory request strobe.
REQ-011 we_o  out  1: 1 = write, 0 = read.
REQ-012 addr_o  out  ADDR_W: memory word address.
REQ-013 wdata_o  out  32: write data.
REQ-014 wmask_o  out  4: byte write mask.
REQ-015 rdata_i  in  32: read data; valid only when rvalid_i=1.
REQ-016 rvalid_i  in  1: read data valid, one cycle after the read request.
REQ-017 busy_o  out  1: a load is in progress.
REQ-018 done_o  out  1: the last load completed successfully; sticky.
REQ-019 err_o  out  1: the last load failed; sticky.
REQ-020 core_rst_o  out  1: active-high hold-in-reset for the core that fetches from memory.

Function
REQ-021 Stream format SHALL be: 2 header bytes giving word count N (little-endian, low byte first), then 4N data bytes, each word little-endian (first byte -> wdata_o[7:0]).
REQ-022 States SHALL be IDLE, HDR0, HDR1, DATA, WRITE, RD, RWAIT, DONE and ERR.
REQ-023 Transitions:
- IDLE/DONE/ERR -> HDR0 on start_i; this also clears done_o and err_o and sets core_rst_o=1.
- HDR0 -> HDR1 on byte accept.
- HDR1 -> DATA on byte accept if 1<=N<=MAX_WORDS; otherwise -> ERR.
- DATA -> WRITE on the 4th byte of a word.
- WRITE -> RD if the verify feature is compiled in; otherwise -> DATA, or -> DONE after word N.
REQ-024 byte_ready_o SHALL be 1 only in HDR0, HDR1 and DATA.
REQ-025 In WRITE, for exactly one cycle: req_o=1, we_o=1, wmask_o=4'hF, addr_o=BASE_ADDR+index, wdata_o=assembled word. The write SHALL start in the cycle after the 4th byte is accepted.
REQ-026 Outside WRITE and RD, req_o=0, we_o=0 and wmask_o=0.
REQ-027 The word index SHALL start at 0 and increment after each word completes; it SHALL never exceed N-1, and there is no wrap.
REQ-028 Entering DONE SHALL set done_o=1 and core_rst_o=0.
REQ-029 Entering ERR SHALL set err_o=1 and leave core_rst_o=1.
REQ-030 busy_o SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-031 Bytes offered in IDLE, DONE, ERR, WRITE, RD and RWAIT SHALL be held off (not accepted, not lost).
REQ-032 When start_i coincides with the final-word transition into DONE, start_i SHALL be ignored.
REQ-033 Throughput without the verify feature: byte_ready_o SHALL return to 1 two cycles after the 4th byte is accepted.

Reset
REQ-034 On rst_i, regardless of state (including mid-load), the block SHALL go to IDLE with: busy_o=0, done_o=0, err_o=0, core_rst_o=1, byte_ready_o=0, req_o=0, we_o=0, wmask_o=0, addr_o=0, wdata_o=0, index=0, and the byte counter cleared.
REQ-035 A partially written image SHALL NOT be reported as done after reset.

Configuration
REQ-036 Macro ICCM_LOADER_VERIFY_EN.
- Defined: after each WRITE, RD issues one cycle with req_o=1, we_o=0 at the same addr_o.
- RWAIT then waits for rvalid_i. On rvalid_i, rdata_i != written word -> ERR; a match -> DATA, or -> DONE after word N.
- If rvalid_i has not arrived 8 cycles after RD, the block SHALL go to ERR.
- Throughput becomes 4 cycles from the 4th byte to the next byte_ready_o.
REQ-037 Macro undefined: the RD and RWAIT states, the compare logic and the timeout logic SHALL be absent, and rdata_i and rvalid_i SHALL be unused.

Verification
REQ-038 N=2, bytes 02 00 78 56 34 12 EF BE AD DE -> writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 1, each with wmask 4'hF; then done_o=1 and core_rst_o=0.
REQ-039 Header 00 00 -> err_o=1, no req_o pulse, core_rst_o stays 1. Header 01 04 (N=1025) -> same result.
REQ-040 rst_i asserted after 3 of 4 data bytes, then start_i and a full N=1 image -> exactly one write with the new word; done_o=1.
REQ-041 start_i pulsed while in DATA -> ignored: no state change, and the load completes normally.
REQ-042 VERIFY_EN defined, memory model corrupts rdata_i bit 0 on word 1 of 3 -> err_o=1 after the word-1 compare, and no write to addr 2.
REQ-043 VERIFY_EN defined, rvalid_i held low -> err_o=1 exactly 8 cycles after the read request.
